mezclador_ruido: RTL

MEZCLADOR_RUIDO -- requirements
Module: mezclador_ruido

---
 rtl/mezclador_ruido.sv | 115 +++++++++++
 1 files changed

// File: rtl/mezclador_ruido.sv
// Noise mixer: adds gain-scaled, offset-binary noise to a clean signed sample.
// 3-stage free-running pipeline with output saturation and a saturation counter.
module mezclador_ruido #(
  parameter int DATA_WIDTH = 16,
  parameter int NOISE_BITS = 14,
  parameter int GAIN_SHIFT = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] dato_limpio,
  input  logic [31:0]           dato_ruidoso,
  input  logic [7:0]            noise_gain,
  input  logic                  sat_clr,
  output logic [DATA_WIDTH-1:0] dato_out,
  output logic                  data_out_valid,
  output logic                  sat_flag,
  output logic [15:0]           sat_count
);

  localparam int NcW   = NOISE_BITS + 1;
  localparam int ProdW = NOISE_BITS + 9;
  localparam int SumW  = DATA_WIDTH + 2;

  // Stage 1 registers
  logic [DATA_WIDTH-1:0] s1_clean_q;
  logic [7:0]            s1_gain_q;
  logic                  s1_en_q, s1_vld_q;
  logic [NcW-1:0]        s1_noise_q, s1_noise_d;

  // Stage 2 registers
  logic [DATA_WIDTH-1:0] s2_clean_q;
  logic [ProdW-1:0]      s2_prod_q, s2_prod_d;
  logic                  s2_vld_q;

  // Stage 3 (output) registers
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_vld_q, sat_q;
  logic [15:0]           cnt_q, cnt_d;

  logic [ProdW-1:0]      noise_ext, gain_ext, shifted;
  logic [SumW-1:0]       sum;
  logic                  ovf;
  logic                  unused_bits;

  // Offset binary minus half-scale is just the MSB inverted, then sign-extended.
  assign s1_noise_d = {{2{~dato_ruidoso[NOISE_BITS-1]}}, dato_ruidoso[NOISE_BITS-2:0]};

  assign noise_ext = {{(ProdW-NcW){s1_noise_q[NcW-1]}}, s1_noise_q};
  assign gain_ext  = {{(ProdW-8){1'b0}}, s1_gain_q};
  assign s2_prod_d = s1_en_q ? ProdW'($signed(noise_ext) * $signed(gain_ext)) : '0;

  assign shifted = ProdW'($signed(s2_prod_q) >>> GAIN_SHIFT);
  assign sum     = {{2{s2_clean_q[DATA_WIDTH-1]}}, s2_clean_q} + shifted[SumW-1:0];

  // Overflow whenever the bits above the output sign are not a pure sign extension.
  assign ovf = ~(&sum[SumW-1:DATA_WIDTH-1]) & (|sum[SumW-1:DATA_WIDTH-1]);

  assign unused_bits = ^{dato_ruidoso[31:NOISE_BITS], shifted[ProdW-1:SumW]};

  always_comb begin
    out_d = sum[DATA_WIDTH-1:0];
    if (ovf) begin
      out_d = sum[SumW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (s2_vld_q && ovf && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_clean_q <= '0;
      s1_gain_q  <= '0;
      s1_en_q    <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_noise_q <= '0;
      s2_clean_q <= '0;
      s2_prod_q  <= '0;
      s2_vld_q   <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_clean_q <= dato_limpio;
      s1_gain_q  <= noise_gain;
      s1_en_q    <= enable;
      s1_vld_q   <= data_valid;
      s1_noise_q <= s1_noise_d;
      s2_clean_q <= s1_clean_q;
      s2_prod_q  <= s2_prod_d;
      s2_vld_q   <= s1_vld_q;
      out_vld_q  <= s2_vld_q;
      cnt_q      <= cnt_d;
      if (s2_vld_q) begin
        out_q <= out_d;
        sat_q <= ovf;
      end
    end
  end

  assign dato_out       = out_q;
  assign data_out_valid = out_vld_q;
  assign sat_flag       = sat_q;
  assign sat_count      = cnt_q;

endmodule
